// File: rtl/mips_timer_pkg.sv
// Shared definitions for the memory-mapped MIPS down-counter timer:
// register offsets, CTRL field positions, mode codes and FSM states.
package mips_timer_pkg;

  // Word offsets on the data bus (address bits [3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // CTRL field layout; only the low CTRL_W bits are implemented
  localparam int CTRL_W       = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Only this code reloads; every other MODE value behaves as one-shot
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  function automatic logic isPeriodic(input logic [1:0] mode);
    return mode == MODE_PERIODIC;
  endfunction

endpackage

// File: rtl/mips_timer.sv
// Programmable down-counter timer on the CPU data-memory bus. Software
// writes PRESET/CTRL; the counter runs from PRESET to expiry, then raises
// pending and either stops (one-shot) or reloads (periodic).
module mips_timer
  import mips_timer_pkg::*;
#(
  parameter int               DATA_W     = 32,
  parameter logic [DATA_W-1:0] PRESET_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  localparam logic [DATA_W-1:0] W_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_stateNext;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_preset;
  logic [DATA_W-1:0]   r_count;
  logic                r_pending;

  logic [DATA_W-1:0]   w_countNext;
  logic                w_setPend;
  logic                w_hwClrPend;
  logic                w_hwClrEn;
  logic                w_en;
  logic                w_wrCtrl;
  logic                w_wrPreset;

  assign w_en       = r_ctrl[CTRL_EN];
  assign w_wrCtrl   = we && (addr == ADDR_CTRL);
  assign w_wrPreset = we && (addr == ADDR_PRESET);

  // Next-state and counter update, decided from register values before any same-edge CPU write
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_setPend   = 1'b0;
    w_hwClrPend = 1'b0;
    w_hwClrEn   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_en) w_stateNext = ST_LOAD;
      end
      ST_LOAD: begin
        w_countNext = (r_preset == '0) ? W_ONE : r_preset;
        w_stateNext = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_stateNext = ST_IDLE;
        end else if (r_count <= W_ONE) begin
          w_countNext = '0;
          w_setPend   = 1'b1;
          w_stateNext = ST_INT;
        end else begin
          w_countNext = r_count - W_ONE;
        end
      end
      ST_INT: begin
        if (isPeriodic(r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
          w_hwClrPend = 1'b1;
          w_stateNext = ST_LOAD;
        end else begin
          w_hwClrEn   = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
    endcase
  end

  // Register bank and FSM state; CPU CTRL writes beat the hardware EN clear, pending set beats clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= '0;
      r_preset  <= PRESET_RST;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      if (w_wrCtrl) begin
        r_ctrl <= wdata[CTRL_W-1:0];
      end else if (w_hwClrEn) begin
        r_ctrl[CTRL_EN] <= 1'b0;
      end
      if (w_wrPreset) begin
        r_preset <= wdata;
      end
      if (w_setPend) begin
        r_pending <= 1'b1;
      end else if (w_wrCtrl || w_wrPreset || w_hwClrPend) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Zero-latency read mux; reserved offset reads as zero
  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_CTRL:   rdata = {{(DATA_W-CTRL_W){1'b0}}, r_ctrl};
      ADDR_PRESET: rdata = r_preset;
      ADDR_COUNT:  rdata = r_count;
      default:     rdata = '0;
    endcase
  end

  assign irq = r_ctrl[CTRL_IM] & r_pending;

endmodule

// File: tb/tb_mips_timer.sv
// Bench for mips_timer: a cycle-level behavioural model of the timer is
// stepped at every clock edge and all four read offsets plus irq are
// compared after each edge. Directed scenarios add literal expectations.
module tb_mips_timer;

  localparam int DATA_W = 32;
  localparam logic [31:0] PRESET_RST = 32'd0;

  logic        clk;
  logic        tbRst;
  logic [1:0]  tbAddr;
  logic        tbWe;
  logic [31:0] tbWdata;
  logic [31:0] rdata;
  logic        irq;

  int nVec  = 0;
  int nMiss = 0;

  // Model state: software-visible registers plus activity flags
  logic [3:0]  mCtrl;
  logic [31:0] mPreset;
  logic [31:0] mCount;
  bit          mPending;
  bit          mArmed;
  bit          mCounting;
  bit          mFired;

  logic [31:0] dutRd [4];
  logic        dutIrq;

  mips_timer #(.DATA_W(DATA_W), .PRESET_RST(PRESET_RST)) dut (
    .clk   (clk),
    .rst   (tbRst),
    .addr  (tbAddr),
    .we    (tbWe),
    .wdata (tbWdata),
    .rdata (rdata),
    .irq   (irq)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] expRead(input int a);
    case (a)
      0:       return {28'd0, mCtrl};
      1:       return mPreset;
      2:       return mCount;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs held across it
  task automatic modelStep();
    bit          en, periodic, setP, clrP, clrEn;
    bit          nArmed, nCounting, nFired;
    logic [31:0] nCount;
    if (!tbRst) begin
      mCtrl = 4'd0; mPreset = PRESET_RST; mCount = 32'd0; mPending = 0;
      mArmed = 0; mCounting = 0; mFired = 0;
      return;
    end
    en = mCtrl[0];
    periodic = (mCtrl[2:1] == 2'b01);
    setP = 0; clrP = 0; clrEn = 0;
    nArmed = mArmed; nCounting = mCounting; nFired = mFired; nCount = mCount;
    if (mFired) begin
      nFired = 0;
      if (periodic) begin clrP = 1; nArmed = 1; end
      else clrEn = 1;
    end else if (mArmed) begin
      nArmed = 0; nCounting = 1;
      nCount = (mPreset == 0) ? 32'd1 : mPreset;
    end else if (mCounting) begin
      if (!en) nCounting = 0;
      else if (mCount <= 1) begin
        nCount = 0; setP = 1; nCounting = 0; nFired = 1;
      end else nCount = mCount - 1;
    end else if (en) begin
      nArmed = 1;
    end
    if (clrEn) mCtrl[0] = 1'b0;
    if (tbWe && tbAddr == 2'd0) begin mCtrl = tbWdata[3:0]; clrP = 1; end
    if (tbWe && tbAddr == 2'd1) begin mPreset = tbWdata; clrP = 1; end
    if (setP) mPending = 1;
    else if (clrP) mPending = 0;
    mCount = nCount; mArmed = nArmed; mCounting = nCounting; mFired = nFired;
  endtask

  // Sweep every read offset and irq against the model
  task automatic checkOutput();
    for (int a = 0; a < 4; a++) begin
      tbAddr = a[1:0];
      #1;
      dutRd[a] = rdata;
      cmp($sformatf("rdata_addr%0d", a), rdata, expRead(a));
    end
    dutIrq = irq;
    cmp("irq", {31'd0, irq}, {31'd0, mCtrl[3] & mPending});
  endtask

  task automatic applyStimulus(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
    tbRst = r; tbWe = w; tbAddr = a; tbWdata = d;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 2'd0, 32'd0);
  endtask

  initial begin
    tbRst = 0; tbWe = 0; tbAddr = 0; tbWdata = 0;
    mCtrl = 0; mPreset = PRESET_RST; mCount = 0; mPending = 0;
    mArmed = 0; mCounting = 0; mFired = 0;

    // Reset held with writes attempted
    applyStimulus(0, 1, 2'd0, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 2'd1, 32'hFFFF_FFFF);
    cmp("rst_ctrl", dutRd[0], 32'd0);
    cmp("rst_count", dutRd[2], 32'd0);
    cmp("rst_irq", {31'd0, dutIrq}, 32'd0);
    idle(1);
    cmp("rst_preset", dutRd[1], PRESET_RST);

    // One-shot, PRESET=5
    applyStimulus(1, 1, 2'd1, 32'd5);
    applyStimulus(1, 1, 2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      if (k >= 2 && k <= 6) cmp($sformatf("oneshot_count_E%0d", k), dutRd[2], 32'(7 - k));
      if (k == 6) cmp("model_count_E6", mCount, 32'd1);
      cmp($sformatf("oneshot_irq_E%0d", k), {31'd0, dutIrq}, (k >= 7) ? 32'd1 : 32'd0);
    end
    cmp("oneshot_ctrl_E8", dutRd[0], 32'h8);
    idle(3);
    cmp("oneshot_irq_held", {31'd0, dutIrq}, 32'd1);
    applyStimulus(1, 1, 2'd0, 32'h8);
    cmp("oneshot_irq_cleared", {31'd0, dutIrq}, 32'd0);

    // Periodic, PRESET=3
    applyStimulus(1, 1, 2'd1, 32'd3);
    applyStimulus(1, 1, 2'd0, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      int ph;
      idle(1);
      ph = (k - 2) % 5;
      if (k >= 2)
        cmp($sformatf("periodic_count_E%0d", k), dutRd[2],
            (ph == 0) ? 32'd3 : (ph == 1) ? 32'd2 : (ph == 2) ? 32'd1 : 32'd0);
      cmp($sformatf("periodic_irq_E%0d", k), {31'd0, dutIrq},
          (k >= 5 && (k - 5) % 5 == 0) ? 32'd1 : 32'd0);
    end
    applyStimulus(1, 1, 2'd0, 32'h8);
    idle(4);

    // Pause at COUNT=7, then restart reloads PRESET
    applyStimulus(1, 1, 2'd1, 32'd10);
    applyStimulus(1, 1, 2'd0, 32'h9);
    idle(4);
    applyStimulus(1, 1, 2'd0, 32'h8);
    cmp("pause_count_at_write", dutRd[2], 32'd7);
    idle(5);
    cmp("pause_count_held", dutRd[2], 32'd7);
    cmp("pause_irq", {31'd0, dutIrq}, 32'd0);
    applyStimulus(1, 1, 2'd0, 32'h9);
    idle(2);
    cmp("pause_reload", dutRd[2], 32'd10);
    applyStimulus(1, 1, 2'd0, 32'h0);
    idle(3);

    // Masked expiry with PRESET=0, then unmasking write clears pending
    applyStimulus(1, 1, 2'd1, 32'd0);
    applyStimulus(1, 1, 2'd0, 32'h1);
    idle(5);
    cmp("masked_irq", {31'd0, dutIrq}, 32'd0);
    cmp("masked_en_cleared", dutRd[0], 32'h0);
    applyStimulus(1, 1, 2'd0, 32'h8);
    idle(2);
    cmp("masked_unmask_irq", {31'd0, dutIrq}, 32'd0);

    // Reset in the middle of a count
    applyStimulus(1, 1, 2'd1, 32'd10);
    applyStimulus(1, 1, 2'd0, 32'h9);
    idle(8);
    cmp("midrst_count_before", dutRd[2], 32'd4);
    applyStimulus(0, 0, 2'd0, 32'd0);
    cmp("midrst_ctrl", dutRd[0], 32'd0);
    cmp("midrst_count", dutRd[2], 32'd0);
    idle(15);
    cmp("midrst_irq", {31'd0, dutIrq}, 32'd0);
    applyStimulus(1, 1, 2'd2, 32'h55);
    applyStimulus(1, 1, 2'd3, 32'h55);
    cmp("count_write_ignored", dutRd[2], 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bit          r, w;
      logic [1:0]  a;
      logic [31:0] d;
      r = ($urandom_range(0, 127) != 0);
      w = ($urandom_range(0, 3) == 0);
      a = 2'($urandom_range(0, 3));
      d = (a == 2'd1) ? 32'($urandom_range(0, 8)) : $urandom;
      applyStimulus(r, w, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
